// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, PC-select codes
// and the register-match helper used by hazard detection.
package pipe_hazard_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } ctrlState_t;

    typedef enum logic [1:0] {
        PCSEL_SEQ = 2'd0,
        PCSEL_EXC = 2'd1,
        PCSEL_EPC = 2'd2
    } pcSel_t;

    // Register 0 is hardwired to zero, so it can never create a dependency.
    function automatic logic regMatch(input logic [4:0] writer, input logic [4:0] reader);
        return (reader != 5'd0) && (writer == reader);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
// HI/LO busy-time counter: loads a cycle count when a mult/div issues and counts down to zero.
module md_busy_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] loadVal,
    output logic             busy
);

    logic [CNT_W-1:0] count;

    // A new issue always restarts the busy period, even if one is still running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard stalls, MDU busy tracking and
// exception/ERET redirect. Optional perf counters are built with PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [4:0]        RsD,
    input  logic [4:0]        RtD,
    input  logic              UseRsD,
    input  logic              UseRtD,
    input  logic              BranchD,
    input  logic              RegWriteE,
    input  logic              MemtoRegE,
    input  logic [4:0]        RegAddrE,
    input  logic              MemtoRegM,
    input  logic [4:0]        RegAddrM,
    input  logic              MdStartE,
    input  logic              MdIsDivE,
    input  logic              MdUseD,
    input  logic              ExcOccurM,
    input  logic              EretD,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              ClrD,
    output logic              ClrE,
    output logic              ClrM,
    output logic              ClrW,
    output logic [1:0]        PcSel,
    output logic              MdBusy,
    output logic [WORD_W-1:0] StallCnt,
    output logic [WORD_W-1:0] FlushCnt
);

    ctrlState_t       state;
    ctrlState_t       nextState;
    logic             loadUseHaz;
    logic             branchHaz;
    logic             mduHaz;
    logic             anyHaz;
    logic             mdStart;
    logic [CNT_W-1:0] mdLoadVal;

    assign loadUseHaz = MemtoRegE &
                        ((UseRsD & regMatch(RegAddrE, RsD)) | (UseRtD & regMatch(RegAddrE, RtD)));
    assign branchHaz  = BranchD &
                        ((RegWriteE & (regMatch(RegAddrE, RsD) | regMatch(RegAddrE, RtD))) |
                         (MemtoRegM & (regMatch(RegAddrM, RsD) | regMatch(RegAddrM, RtD))));
    assign mduHaz     = MdUseD & (MdBusy | MdStartE);
    assign anyHaz     = loadUseHaz | branchHaz | mduHaz;

    // An exception in M kills the mult/div sitting in E, so it must not occupy HI/LO.
    assign mdStart   = MdStartE & ~ExcOccurM;
    assign mdLoadVal = MdIsDivE ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

    md_busy_counter #(
        .CNT_W(CNT_W)
    ) u_mdBusy (
        .clk    (clk),
        .reset  (reset),
        .start  (mdStart),
        .loadVal(mdLoadVal),
        .busy   (MdBusy)
    );

    assign StallE = 1'b0;
    assign ClrW   = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    // Priority: exception > hazard stall > eret > normal; outputs forced low while in reset.
    always_comb begin
        nextState = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        ClrD      = 1'b0;
        ClrE      = 1'b0;
        ClrM      = 1'b0;
        PcSel     = PCSEL_SEQ;
        if (reset) begin
            if (ExcOccurM) begin
                ClrD      = 1'b1;
                ClrE      = 1'b1;
                ClrM      = 1'b1;
                PcSel     = PCSEL_EXC;
                nextState = ST_FLUSH;
            end else if (state == ST_FLUSH) begin
                ClrD      = 1'b1;
                nextState = ST_RUN;
            end else if (anyHaz) begin
                StallF = 1'b1;
                StallD = 1'b1;
                ClrE   = 1'b1;
            end else if (EretD) begin
                ClrD  = 1'b1;
                PcSel = PCSEL_EPC;
            end
        end
    end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            StallCnt <= '0;
            FlushCnt <= '0;
        end else begin
            if (StallD) begin
                StallCnt <= StallCnt + 1'b1;
            end
            if (PcSel != PCSEL_SEQ) begin
                FlushCnt <= FlushCnt + 1'b1;
            end
        end
    end
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; expected control vectors are hand-derived.
module tb_pipe_hazard_ctrl;

    // Control vector layout: {StallF, StallD, StallE, ClrD, ClrE, ClrM, ClrW, PcSel[1:0]}
    localparam logic [8:0] CTRL_NONE  = 9'b0_0_0_0_0_0_0_00;
    localparam logic [8:0] CTRL_STALL = 9'b1_1_0_0_1_0_0_00;
    localparam logic [8:0] CTRL_EXC   = 9'b0_0_0_1_1_1_0_01;
    localparam logic [8:0] CTRL_FLUSH = 9'b0_0_0_1_0_0_0_00;
    localparam logic [8:0] CTRL_ERET  = 9'b0_0_0_1_0_0_0_10;

    logic        clk;
    logic        reset;
    logic [4:0]  RsD, RtD, RegAddrE, RegAddrM;
    logic        UseRsD, UseRtD, BranchD, RegWriteE, MemtoRegE, MemtoRegM;
    logic        MdStartE, MdIsDivE, MdUseD, ExcOccurM, EretD;
    logic        StallF, StallD, StallE, ClrD, ClrE, ClrM, ClrW, MdBusy;
    logic [1:0]  PcSel;
    logic [31:0] StallCnt, FlushCnt;
    logic [8:0]  ctrlVec;

    int compareCount  = 0;
    int mismatchCount = 0;
    int expStall      = 0;
    int expFlush      = 0;

    pipe_hazard_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .RsD      (RsD),
        .RtD      (RtD),
        .UseRsD   (UseRsD),
        .UseRtD   (UseRtD),
        .BranchD  (BranchD),
        .RegWriteE(RegWriteE),
        .MemtoRegE(MemtoRegE),
        .RegAddrE (RegAddrE),
        .MemtoRegM(MemtoRegM),
        .RegAddrM (RegAddrM),
        .MdStartE (MdStartE),
        .MdIsDivE (MdIsDivE),
        .MdUseD   (MdUseD),
        .ExcOccurM(ExcOccurM),
        .EretD    (EretD),
        .StallF   (StallF),
        .StallD   (StallD),
        .StallE   (StallE),
        .ClrD     (ClrD),
        .ClrE     (ClrE),
        .ClrM     (ClrM),
        .ClrW     (ClrW),
        .PcSel    (PcSel),
        .MdBusy   (MdBusy),
        .StallCnt (StallCnt),
        .FlushCnt (FlushCnt)
    );

    assign ctrlVec = {StallF, StallD, StallE, ClrD, ClrE, ClrM, ClrW, PcSel};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        RsD = 5'd0; RtD = 5'd0; RegAddrE = 5'd0; RegAddrM = 5'd0;
        UseRsD = 1'b0; UseRtD = 1'b0; BranchD = 1'b0; RegWriteE = 1'b0;
        MemtoRegE = 1'b0; MemtoRegM = 1'b0; MdStartE = 1'b0; MdIsDivE = 1'b0;
        MdUseD = 1'b0; ExcOccurM = 1'b0; EretD = 1'b0;
    endtask

    // Advance to the next falling edge and return inputs to an idle pipeline.
    task automatic applyStimulus();
        @(negedge clk);
        idleInputs();
    endtask

    // Check this cycle's outputs and note which perf events the edge should record.
    task automatic expectStep(input string tag, input logic [8:0] expCtrl, input logic expBusy);
        #1;
        checkOutput({tag, " ctrl"}, {23'd0, ctrlVec}, {23'd0, expCtrl});
        checkOutput({tag, " busy"}, {31'd0, MdBusy}, {31'd0, expBusy});
        if (expCtrl[7]) expStall++;
        if (expCtrl[1:0] != 2'b00) expFlush++;
    endtask

    task automatic checkCounters(input string tag);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
        checkOutput({tag, " stallCnt"}, StallCnt, 32'(expStall));
        checkOutput({tag, " flushCnt"}, FlushCnt, 32'(expFlush));
`else
        checkOutput({tag, " stallCnt"}, StallCnt, 32'd0);
        checkOutput({tag, " flushCnt"}, FlushCnt, 32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0;
        idleInputs();
        applyStimulus();
        expectStep("reset", CTRL_NONE, 1'b0);
        checkCounters("reset");
        reset = 1'b1;

        // Load-use on Rs, then the load reaches M and forwarding covers it.
        applyStimulus();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expectStep("ldUseRs", CTRL_STALL, 1'b0);
        applyStimulus();
        MemtoRegM = 1'b1; RegAddrM = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expectStep("ldUseClear", CTRL_NONE, 1'b0);
        applyStimulus();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd0; RsD = 5'd0; UseRsD = 1'b1;
        expectStep("ldUseReg0", CTRL_NONE, 1'b0);
        applyStimulus();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd9; RtD = 5'd9; UseRtD = 1'b1;
        expectStep("ldUseRt", CTRL_STALL, 1'b0);
        applyStimulus();
        MemtoRegE = 1'b1; RegWriteE = 1'b1; RegAddrE = 5'd9; RtD = 5'd9; UseRtD = 1'b0;
        expectStep("ldUseNoRead", CTRL_NONE, 1'b0);

        // Branch on $t1: ALU writer in E, then load writer in M, then clear.
        applyStimulus();
        BranchD = 1'b1; RsD = 5'd9; RegWriteE = 1'b1; RegAddrE = 5'd9;
        expectStep("brE", CTRL_STALL, 1'b0);
        applyStimulus();
        BranchD = 1'b1; RsD = 5'd9; MemtoRegM = 1'b1; RegAddrM = 5'd9;
        expectStep("brM", CTRL_STALL, 1'b0);
        applyStimulus();
        BranchD = 1'b1; RsD = 5'd9;
        expectStep("brClear", CTRL_NONE, 1'b0);
        applyStimulus();
        BranchD = 1'b1; RsD = 5'd9; RegWriteE = 1'b1; RegAddrE = 5'd10;
        expectStep("brOtherReg", CTRL_NONE, 1'b0);

        // div issues, mflo waits in D for the whole busy period.
        applyStimulus();
        MdStartE = 1'b1; MdIsDivE = 1'b1;
        expectStep("divIssue", CTRL_NONE, 1'b0);
        for (int k = 1; k <= 11; k++) begin
            applyStimulus();
            MdUseD = 1'b1;
            expectStep($sformatf("divWait%0d", k), (k <= 10) ? CTRL_STALL : CTRL_NONE, k <= 10);
        end

        // mult with HI/LO reader in D, then a second mult restarts the busy period.
        applyStimulus();
        MdStartE = 1'b1; MdUseD = 1'b1;
        expectStep("multIssue", CTRL_STALL, 1'b0);
        applyStimulus();
        expectStep("mult1", CTRL_NONE, 1'b1);
        applyStimulus();
        expectStep("mult2", CTRL_NONE, 1'b1);
        applyStimulus();
        MdStartE = 1'b1;
        expectStep("multReload", CTRL_NONE, 1'b1);
        for (int k = 4; k <= 9; k++) begin
            applyStimulus();
            expectStep($sformatf("multRun%0d", k), CTRL_NONE, k <= 8);
        end
        checkCounters("mid");

        // An older div keeps running across an exception flush.
        applyStimulus();
        MdStartE = 1'b1; MdIsDivE = 1'b1;
        expectStep("divBeforeExc", CTRL_NONE, 1'b0);
        applyStimulus();
        ExcOccurM = 1'b1;
        expectStep("excDivRun", CTRL_EXC, 1'b1);
        applyStimulus();
        expectStep("flushDivRun", CTRL_FLUSH, 1'b1);
        applyStimulus();
        expectStep("runDivRun", CTRL_NONE, 1'b1);
        for (int k = 0; k < 8; k++) begin
            applyStimulus();
            expectStep($sformatf("divDrain%0d", k), CTRL_NONE, k < 7);
        end

        // Exception kills a mult/div issuing in E.
        applyStimulus();
        ExcOccurM = 1'b1; MdStartE = 1'b1; MdIsDivE = 1'b1;
        expectStep("excKillMd", CTRL_EXC, 1'b0);
        applyStimulus();
        expectStep("excKillFlush", CTRL_FLUSH, 1'b0);
        applyStimulus();
        expectStep("excKillRun", CTRL_NONE, 1'b0);

        // Exception beats a hazard, repeats in FLUSH, and FLUSH ignores hazards.
        applyStimulus();
        MemtoRegE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1; ExcOccurM = 1'b1;
        expectStep("excOverHaz", CTRL_EXC, 1'b0);
        applyStimulus();
        ExcOccurM = 1'b1;
        expectStep("excInFlush", CTRL_EXC, 1'b0);
        applyStimulus();
        MemtoRegE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expectStep("flushIgnHaz", CTRL_FLUSH, 1'b0);
        applyStimulus();
        MemtoRegE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expectStep("hazAfterFlush", CTRL_STALL, 1'b0);

        // ERET behind a load-use stall, then redirect; exception beats eret.
        applyStimulus();
        EretD = 1'b1; MemtoRegE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expectStep("eretStall", CTRL_STALL, 1'b0);
        applyStimulus();
        EretD = 1'b1;
        expectStep("eretGo", CTRL_ERET, 1'b0);
        applyStimulus();
        expectStep("eretAfter", CTRL_NONE, 1'b0);
        applyStimulus();
        EretD = 1'b1; ExcOccurM = 1'b1;
        expectStep("excOverEret", CTRL_EXC, 1'b0);
        applyStimulus();
        expectStep("excOverEretFl", CTRL_FLUSH, 1'b0);
        applyStimulus();
        expectStep("excOverEretRun", CTRL_NONE, 1'b0);
        checkCounters("preReset");

        // Reset in the middle of a div discards the count at once.
        applyStimulus();
        MdStartE = 1'b1; MdIsDivE = 1'b1;
        expectStep("rstDivIssue", CTRL_NONE, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus();
            expectStep($sformatf("rstDivRun%0d", k), CTRL_NONE, 1'b1);
        end
        applyStimulus();
        reset = 1'b0;
        MdUseD = 1'b1; MemtoRegE = 1'b1; RegAddrE = 5'd8; RsD = 5'd8; UseRsD = 1'b1;
        expStall = 0;
        expFlush = 0;
        expectStep("midReset", CTRL_NONE, 1'b0);
        checkCounters("midReset");
        applyStimulus();
        reset = 1'b1;
        MdUseD = 1'b1;
        expectStep("postReset", CTRL_NONE, 1'b0);
        applyStimulus();
        checkCounters("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
